// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, MS digit first, acc*10+d.
// Optional nibble range check is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin_seq #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state_q;
    logic [4*DIGITS-1:0] sr_q;
    logic [BIN_W-1:0]    acc_q;
    logic [BIN_W-1:0]    bin_q;
    logic [CW-1:0]       cnt_q;
    logic                ovf_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [3:0]          dig;
    logic [BIN_W+3:0]    acc_x;
    logic [BIN_W+3:0]    nxt;
    logic                ovf_d;
    logic [BIN_W-1:0]    res_d;

    assign dig   = sr_q[4*DIGITS-1 -: 4];
    assign acc_x = {4'b0000, acc_q};
    // Four guard bits catch any carry out of the truncated accumulator.
    assign nxt   = (acc_x << 3) + (acc_x << 1) + {{BIN_W{1'b0}}, dig};
    assign ovf_d = ovf_q | (nxt[BIN_W+3:BIN_W] != 4'd0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_q;
    logic err_d;
    assign err_d = err_q | (dig > 4'd9);
    assign res_d = err_d ? '0 : nxt[BIN_W-1:0];
    assign err   = err_q;
`else
    assign res_d = nxt[BIN_W-1:0];
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q       <= bcd_in;
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= CW'(DIGITS - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                CONV: begin
                    acc_q <= nxt[BIN_W-1:0];
                    ovf_q <= ovf_d;
                    sr_q  <= sr_q << 4;
                    cnt_q <= cnt_q - 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    err_q <= err_d;
`endif
                    // Result is registered on the last digit so it is stable throughout DONE.
                    if (cnt_q == '0) begin
                        bin_q       <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized self-checking bench for bcd_to_bin_seq against an arithmetic reference model.
module tb_bcd_to_bin_seq;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bcd_in = '0;
    logic        in_valid = 1'b0, in_ready, err, ovf, out_valid, out_ready = 1'b0;
    logic [26:0] bin_out;
    logic [19:0] s_bcd_in = '0;
    logic        s_in_valid = 1'b0, s_in_ready, s_err, s_ovf, s_out_valid, s_out_ready = 1'b0;
    logic [15:0] s_bin_out;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
        .bin_out(bin_out), .err(err), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready));

    bcd_to_bin_seq #(.DIGITS(5), .BIN_W(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .bcd_in(s_bcd_in), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .bin_out(s_bin_out), .err(s_err), .ovf(s_ovf), .out_valid(s_out_valid), .out_ready(s_out_ready));

    // Reference: full decimal value in 64 bits; truncation and overflow follow from it directly.
    function automatic void ref_conv(input logic [31:0] w, input int nd, input int bw,
                                     output longint unsigned bin, output bit e, output bit o);
        longint unsigned v = 0;
        longint unsigned m = 64'd1 << bw;
        e = 1'b0;
        for (int i = nd - 1; i >= 0; i--) begin
            int n = int'((w >> (4 * i)) & 32'hF);
            v = v * 10 + longint'(n);
            if (n > 9) e = CHK;
        end
        o   = (v >= m);
        bin = e ? 64'd0 : (v % m);
    endfunction

    function automatic logic [31:0] rand_bcd(input int nd);
        logic [31:0] w = '0;
        for (int i = 0; i < nd; i++) w[4*i +: 4] = 4'($urandom_range(9));
        return w;
    endfunction

    task automatic run_word(input logic [31:0] w, output int lat, output logic [26:0] b,
                            output logic e, output logic o, output bit to);
        int n = 0;
        lat = 0; b = '0; e = 1'b0; o = 1'b0; to = 1'b0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin to = 1'b1; return; end
        bcd_in = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!out_valid) begin to = 1'b1; return; end
        b = bin_out; e = err; o = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_word_s(input logic [19:0] w, output int lat, output logic [15:0] b,
                              output logic e, output logic o, output bit to);
        int n = 0;
        lat = 0; b = '0; e = 1'b0; o = 1'b0; to = 1'b0;
        while (!s_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!s_in_ready) begin to = 1'b1; return; end
        s_bcd_in = w; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        while (!s_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!s_out_valid) begin to = 1'b1; return; end
        b = s_bin_out; e = s_err; o = s_ovf;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, bin_out, err, ovf} !== {1'b1, 1'b0, 27'd0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_vals: rdy=%b vld=%b bin=%0d err=%b ovf=%b, want rdy=1 vld=0 bin=0 err=0 ovf=0",
                     in_ready, out_valid, bin_out, err, ovf);
        end
        checks++;
        if ({s_in_ready, s_out_valid, s_bin_out, s_err, s_ovf} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_vals_s: rdy=%b vld=%b bin=%0d, want rdy=1 vld=0 bin=0", s_in_ready, s_out_valid, s_bin_out);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL idle_after_reset: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    // Directed words with spec-known answers, cross-checked against both constants and the model.
    task automatic test_directed();
        logic [31:0] words [4] = '{32'h12345678, 32'h99999999, 32'h00000000, 32'h1234567A};
        logic [26:0] consts[4] = '{27'h0BC614E, 27'h5F5E0FF, 27'd0, CHK ? 27'd0 : 27'd12345680};
        for (int i = 0; i < 4; i++) begin
            int lat; logic [26:0] b; logic e, o; bit to;
            longint unsigned xb; bit xe, xo;
            ref_conv(words[i], 8, 27, xb, xe, xo);
            run_word(words[i], lat, b, e, o, to);
            checks++;
            if (to || lat != 8) begin
                errs++;
                $display("FAIL latency_%h: lat=%0d timeout=%0d, want 8", words[i], lat, to);
            end
            checks++;
            if (b !== consts[i] || b !== xb[26:0]) begin
                errs++;
                $display("FAIL bin_%h: got %h, want %h", words[i], b, consts[i]);
            end
            checks++;
            if (e !== xe || o !== xo) begin
                errs++;
                $display("FAIL flags_%h: err=%b ovf=%b, want err=%b ovf=%b", words[i], e, o, xe, xo);
            end
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errs++;
                $display("FAIL handshake_%h: vld=%b rdy=%b, want vld=0 rdy=1", words[i], out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int lat; logic [26:0] b; logic e, o; bit to;
            longint unsigned xb; bit xe, xo;
            logic [31:0] w = ($urandom_range(3) == 0) ? $urandom : rand_bcd(8);
            ref_conv(w, 8, 27, xb, xe, xo);
            run_word(w, lat, b, e, o, to);
            checks++;
            if (to || lat != 8 || b !== xb[26:0] || e !== xe || o !== xo) begin
                errs++;
                $display("FAIL random_%h: lat=%0d to=%0d bin=%h err=%b ovf=%b, want lat=8 bin=%h err=%b ovf=%b",
                         w, lat, to, b, e, o, xb[26:0], xe, xo);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w1 = rand_bcd(8);
        logic [31:0] w2 = rand_bcd(8);
        longint unsigned xb; bit xe, xo;
        int n = 0;
        int lat; logic [26:0] b; logic e, o; bit to;
        ref_conv(w1, 8, 27, xb, xe, xo);
        bcd_in = w1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (!out_valid) begin
            errs++;
            $display("FAIL bp_wait: out_valid never rose, want 1 within 50 cycles");
        end
        // Second word offered throughout the stall and on the handshake edge itself.
        bcd_in = w2; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || bin_out !== xb[26:0] || err !== xe || ovf !== xo || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold_%0d: vld=%b bin=%h err=%b ovf=%b rdy=%b, want vld=1 bin=%h err=%b ovf=%b rdy=0",
                         c, out_valid, bin_out, err, ovf, in_ready, xb[26:0], xe, xo);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL bp_release: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errs++;
                $display("FAIL bp_no_queue_%0d: vld=%b rdy=%b, want vld=0 rdy=1", c, out_valid, in_ready);
            end
        end
        ref_conv(w2, 8, 27, xb, xe, xo);
        run_word(w2, lat, b, e, o, to);
        checks++;
        if (to || lat != 8 || b !== xb[26:0] || e !== xe || o !== xo) begin
            errs++;
            $display("FAIL bp_second_%h: lat=%0d bin=%h, want lat=8 bin=%h", w2, lat, b, xb[26:0]);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] w = rand_bcd(8);
        longint unsigned xb; bit xe, xo;
        int lat; logic [26:0] b; logic e, o; bit to;
        bcd_in = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, bin_out, err, ovf} !== {1'b1, 1'b0, 27'd0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL abort_vals: rdy=%b vld=%b bin=%h err=%b ovf=%b, want rdy=1 vld=0 bin=0 err=0 ovf=0",
                     in_ready, out_valid, bin_out, err, ovf);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errs++;
                $display("FAIL abort_no_valid_%0d: vld=%b, want 0", c, out_valid);
            end
        end
        w = rand_bcd(8);
        ref_conv(w, 8, 27, xb, xe, xo);
        run_word(w, lat, b, e, o, to);
        checks++;
        if (to || lat != 8 || b !== xb[26:0] || e !== xe || o !== xo) begin
            errs++;
            $display("FAIL abort_recover_%h: lat=%0d bin=%h, want lat=8 bin=%h", w, lat, b, xb[26:0]);
        end
    endtask

    task automatic test_overflow();
        logic [19:0] words [6] = '{20'h99999, 20'h65535, 20'h65536, 20'h00000, 20'h70000, 20'h12345};
        logic [15:0] consts[6] = '{16'd34463, 16'd65535, 16'd0, 16'd0, 16'd4464, 16'd12345};
        bit          covf  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            int lat; logic [15:0] b; logic e, o; bit to;
            longint unsigned xb; bit xe, xo;
            ref_conv({12'd0, words[i]}, 5, 16, xb, xe, xo);
            run_word_s(words[i], lat, b, e, o, to);
            checks++;
            if (to || lat != 5 || b !== consts[i] || b !== xb[15:0] || o !== covf[i] || o !== xo || e !== 1'b0) begin
                errs++;
                $display("FAIL ovf_%h: lat=%0d bin=%0d ovf=%b err=%b, want lat=5 bin=%0d ovf=%b err=0",
                         words[i], lat, b, o, e, consts[i], covf[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
